// File: rtl/slc3_instr_decoder.sv
// SLC3 instruction decoder: registered decode into a 2-entry record FIFO, plus a saturating illegal-word counter.
// Define SLC3_GPU_OPS_EN to decode the GPU extension opcodes (WPIX, GRSC, INVR, PUB, BRTN); otherwise they are ILL.
module slc3_instr_decoder #(
  parameter int ILL_CNT_W = 16
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          in_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           op_class,
  output logic [2:0]           dr,
  output logic [2:0]           sr1,
  output logic [2:0]           sr2,
  output logic                 imm_sel,
  output logic [15:0]          imm,
  output logic [2:0]           nzp,
  output logic [7:0]           pix,
  output logic [ILL_CNT_W-1:0] ill_cnt,
  input  logic                 ill_clr
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,  OP_ADD  = 4'd1,  OP_AND = 4'd2,  OP_NOT = 4'd3,
    OP_BR   = 4'd4,  OP_JMP  = 4'd5,  OP_JSR = 4'd6,  OP_LDR = 4'd7,
    OP_STR  = 4'd8,  OP_PSE  = 4'd9,  OP_WPIX = 4'd10, OP_GRSC = 4'd11,
    OP_INVR = 4'd12, OP_PUB  = 4'd13, OP_BRTN = 4'd14, OP_ILL = 4'd15
  } op_e;

  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  dr;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic        imm_sel;
    logic [15:0] imm;
    logic [2:0]  nzp;
    logic [7:0]  pix;
  } rec_t;

  localparam logic [ILL_CNT_W-1:0] ILL_MAX = '1;

  rec_t dec;

  // Every field starts at zero so classes only drive the fields meaningful to them.
  always_comb begin
    dec    = '0;
    dec.op = OP_ILL;
    case (in_instr[15:12])
      4'b0001, 4'b0101: begin
        dec.op  = in_instr[14] ? OP_AND : OP_ADD;
        dec.dr  = in_instr[11:9];
        dec.sr1 = in_instr[8:6];
        if (in_instr[5]) begin
          dec.imm_sel = 1'b1;
          dec.imm     = {{11{in_instr[4]}}, in_instr[4:0]};
        end else begin
          dec.sr2 = in_instr[2:0];
        end
      end
      4'b1001: begin
        dec.op  = OP_NOT;
        dec.dr  = in_instr[11:9];
        dec.sr1 = in_instr[8:6];
      end
      4'b0000: begin
        if (in_instr[11:9] == 3'b000) begin
          dec.op = OP_NOP;
        end else begin
          dec.op  = OP_BR;
          dec.nzp = in_instr[11:9];
          dec.imm = {{7{in_instr[8]}}, in_instr[8:0]};
        end
      end
      4'b1100: begin
        dec.op  = OP_JMP;
        dec.sr1 = in_instr[8:6];
      end
      4'b0100: begin
        if (in_instr[11]) begin
          dec.op  = OP_JSR;
          dec.imm = {{5{in_instr[10]}}, in_instr[10:0]};
        end
      end
      4'b0110, 4'b0111: begin
        dec.op  = in_instr[12] ? OP_STR : OP_LDR;
        dec.dr  = in_instr[11:9];
        dec.sr1 = in_instr[8:6];
        dec.imm = {{10{in_instr[5]}}, in_instr[5:0]};
      end
      4'b1101: begin
        dec.op  = OP_PSE;
        dec.imm = {4'b0000, in_instr[11:0]};
      end
`ifdef SLC3_GPU_OPS_EN
      4'b0010: begin
        if (in_instr[11:8] == 4'hF) begin
          dec.op  = OP_WPIX;
          dec.pix = in_instr[7:0];
        end
      end
      4'b0011: begin
        if (in_instr[11:3] == 9'h000) begin
          dec.op  = OP_BRTN;
          dec.imm = {13'b0, in_instr[2:0]};
        end
      end
      4'b1110: begin
        if (in_instr == 16'hE000)      dec.op = OP_GRSC;
        else if (in_instr == 16'hE800) dec.op = OP_INVR;
        else if (in_instr == 16'hE020) dec.op = OP_PUB;
      end
`endif
      default: ;
    endcase
  end

  rec_t       mem [2];
  rec_t       head;
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;

  // A full FIFO still accepts when the head leaves in the same cycle.
  assign in_ready  = (count != 2'd2) || out_ready;
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (push && !pop)      count <= count + 2'd1;
      else if (!push && pop) count <= count - 2'd1;
    end
  end

  assign head = out_valid ? mem[rd_ptr] : '0;
  assign {op_class, dr, sr1, sr2, imm_sel, imm, nzp, pix} = head;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ill_cnt <= '0;
    end else if (ill_clr) begin
      ill_cnt <= '0;
    end else if (push && dec.op == OP_ILL && ill_cnt != ILL_MAX) begin
      ill_cnt <= ill_cnt + ILL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_slc3_instr_decoder.sv
// Bench for slc3_instr_decoder: directed literal scenarios, then random traffic checked every cycle
// against a queue-based model that decodes from a field-meaning table.
module tb_slc3_instr_decoder;

  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  dr;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic        imm_sel;
    logic [15:0] imm;
    logic [2:0]  nzp;
    logic [7:0]  pix;
  } rec_t;

  logic        Clk;
  logic        Reset_n;
  logic        in_valid, in_ready, out_valid, out_ready, ill_clr;
  logic [15:0] in_instr;
  logic [3:0]  op_class;
  logic [2:0]  dr, sr1, sr2, nzp;
  logic        imm_sel;
  logic [15:0] imm;
  logic [7:0]  pix;
  logic [15:0] ill_cnt;

  logic        in_valid2, in_ready2, out_valid2, out_ready2, ill_clr2;
  logic [15:0] in_instr2;
  logic [3:0]  op_class2;
  logic [2:0]  dr2, sr12, sr22, nzp2;
  logic        imm_sel2;
  logic [15:0] imm2;
  logic [7:0]  pix2;
  logic [1:0]  ill_cnt2;

  logic [40:0] dut_rec;
  assign dut_rec = {op_class, dr, sr1, sr2, imm_sel, imm, nzp, pix};

  int n_pass  = 0;
  int n_total = 0;

  slc3_instr_decoder u_dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .op_class(op_class), .dr(dr), .sr1(sr1), .sr2(sr2), .imm_sel(imm_sel),
    .imm(imm), .nzp(nzp), .pix(pix), .ill_cnt(ill_cnt), .ill_clr(ill_clr)
  );

  slc3_instr_decoder #(.ILL_CNT_W(2)) u_dut2 (
    .Clk(Clk), .Reset_n(Reset_n),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_instr(in_instr2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .op_class(op_class2), .dr(dr2), .sr1(sr12), .sr2(sr22), .imm_sel(imm_sel2),
    .imm(imm2), .nzp(nzp2), .pix(pix2), .ill_cnt(ill_cnt2), .ill_clr(ill_clr2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [15:0] sext(input logic [15:0] w, input int bits);
    int v;
    v = int'(w) & ((1 << bits) - 1);
    if (v >= (1 << (bits - 1))) v -= (1 << bits);
    return 16'(v);
  endfunction

  // Reference decode: pick the class, then keep only the fields that class gives meaning to.
  function automatic rec_t model(input logic [15:0] w);
    rec_t r;
    int   op;
    r = '0;
    case (int'(w[15:12]))
      0:  op = (w[11:9] == 3'b000) ? 0 : 4;
      1:  op = 1;
      5:  op = 2;
      9:  op = 3;
      12: op = 5;
      4:  op = w[11] ? 6 : 15;
      6:  op = 7;
      7:  op = 8;
      13: op = 9;
      default: op = 15;
    endcase
`ifdef SLC3_GPU_OPS_EN
    if (w[15:8] == 8'h2F)  op = 10;
    if (w == 16'hE000)     op = 11;
    if (w == 16'hE800)     op = 12;
    if (w == 16'hE020)     op = 13;
    if (w[15:3] == 13'h0600) op = 14;
`endif
    r.op = 4'(op);
    if (op inside {1, 2, 3, 7, 8})    r.dr  = w[11:9];
    if (op inside {1, 2, 3, 5, 7, 8}) r.sr1 = w[8:6];
    if (op inside {1, 2}) begin
      r.imm_sel = w[5];
      if (w[5]) r.imm = sext(w, 5);
      else      r.sr2 = w[2:0];
    end
    if (op == 4) begin
      r.nzp = w[11:9];
      r.imm = sext(w, 9);
    end
    if (op == 6)            r.imm = sext(w, 11);
    if (op inside {7, 8})   r.imm = sext(w, 6);
    if (op == 9)            r.imm = w & 16'h0FFF;
    if (op == 14)           r.imm = w & 16'h0007;
    if (op == 10)           r.pix = w[7:0];
    return r;
  endfunction

  function automatic logic [40:0] mk(input int op, input int d, input int s1, input int s2,
                                     input int isel, input int im, input int cc, input int px);
    rec_t r;
    r.op = 4'(op); r.dr = 3'(d); r.sr1 = 3'(s1); r.sr2 = 3'(s2);
    r.imm_sel = 1'(isel); r.imm = 16'(im); r.nzp = 3'(cc); r.pix = 8'(px);
    return r;
  endfunction

  // Model state: queue of held records and the illegal-word count.
  rec_t q[$];
  int   m_ill = 0;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      q.delete();
      m_ill = 0;
    end else begin
      bit   rdy, do_push;
      rec_t r;
      rdy     = (q.size() < 2) || out_ready;
      do_push = in_valid && rdy;
      r       = model(in_instr);
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (do_push) q.push_back(r);
      if (ill_clr) m_ill = 0;
      else if (do_push && r.op == 4'd15 && m_ill < 65535) m_ill++;
    end
  end

  always @(negedge Clk) begin
    if (Reset_n) begin
      chk("m_out_valid", out_valid, q.size() > 0);
      chk("m_in_ready", in_ready, (q.size() < 2) || out_ready);
      chk("m_ill_cnt", ill_cnt, m_ill);
      if (q.size() > 0) chk("m_record", dut_rec, q[0]);
    end
  end

  task automatic drive(input logic v, input logic [15:0] w, input logic ordy, input logic clr);
    @(posedge Clk);
    #1;
    in_valid  = v;
    in_instr  = w;
    out_ready = ordy;
    ill_clr   = clr;
  endtask

  task automatic expect_rec(input string nm, input logic [40:0] exp);
    @(negedge Clk);
    chk({nm, "_valid"}, out_valid, 1);
    chk(nm, dut_rec, exp);
  endtask

  function automatic logic [15:0] pick();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 9))
      0: return {8'h2F, r[7:0]};
      1: return 16'hE000;
      2: return 16'hE800;
      3: return 16'hE020;
      4: return {13'h0600, r[2:0]};
      5: return 16'hF000;
      6: return {4'h0, r[11:0]};
      default: return r;
    endcase
  endfunction

  logic [1:0] sat_exp [5];

  initial begin
    Reset_n = 1'b0;
    in_valid = 0; in_instr = 0; out_ready = 0; ill_clr = 0;
    in_valid2 = 0; in_instr2 = 0; out_ready2 = 1; ill_clr2 = 0;
    repeat (3) @(negedge Clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ill_cnt", ill_cnt, 0);
    chk("rst_fields", dut_rec, 0);
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    @(negedge Clk);
    chk("rel_in_ready", in_ready, 1);

    // Register-form ADD with a single-cycle latency.
    drive(1, 16'h1283, 1, 0);
    drive(0, 16'h0000, 1, 0);
    expect_rec("add_reg", mk(1, 1, 2, 3, 0, 0, 0, 0));

    // Back-to-back: immediate ADD, BR with all-ones offset, NOP.
    drive(1, 16'h127F, 1, 0);
    drive(1, 16'h0FFF, 1, 0);
    expect_rec("add_imm", mk(1, 1, 1, 0, 1, 16'hFFFF, 0, 0));
    drive(1, 16'h0000, 1, 0);
    expect_rec("br", mk(4, 0, 0, 0, 0, 16'hFFFF, 7, 0));
    drive(0, 16'h0000, 1, 0);
    expect_rec("nop", mk(0, 0, 0, 0, 0, 0, 0, 0));

    drive(1, 16'h2FE0, 1, 0);
    drive(0, 16'h0000, 1, 0);
`ifdef SLC3_GPU_OPS_EN
    expect_rec("wpix", mk(10, 0, 0, 0, 0, 0, 0, 8'hE0));
    chk("wpix_ill_cnt", ill_cnt, 0);
`else
    expect_rec("wpix_ill", mk(15, 0, 0, 0, 0, 0, 0, 0));
    chk("wpix_ill_cnt", ill_cnt, 1);
`endif

    // Backpressure: two accepted, third held, then drained in order.
    drive(1, 16'h5020, 0, 0);
    drive(1, 16'h9BFF, 0, 0);
    drive(1, 16'hC1C0, 0, 0);
    @(negedge Clk);
    chk("full_in_ready", in_ready, 0);
    chk("full_head", dut_rec, mk(2, 0, 0, 0, 1, 0, 0, 0));
    drive(1, 16'hC1C0, 0, 0);
    @(negedge Clk);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_head", dut_rec, mk(2, 0, 0, 0, 1, 0, 0, 0));
    drive(1, 16'hC1C0, 1, 0);
    @(negedge Clk);
    chk("drain_in_ready", in_ready, 1);
    chk("drain_and", dut_rec, mk(2, 0, 0, 0, 1, 0, 0, 0));
    drive(0, 16'h0000, 1, 0);
    expect_rec("drain_not", mk(3, 5, 7, 0, 0, 0, 0, 0));
    expect_rec("drain_jmp", mk(5, 0, 7, 0, 0, 0, 0, 0));
    @(negedge Clk);
    chk("drain_empty", out_valid, 0);

    // Narrow counter saturates at 3, then clears, including clear racing an ILL acceptance.
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3; sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;
    @(posedge Clk);
    #1 in_valid2 = 1; in_instr2 = 16'hF000;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk);
      #1 chk($sformatf("sat_%0d", i), ill_cnt2, sat_exp[i]);
    end
    in_valid2 = 0; ill_clr2 = 1;
    @(posedge Clk);
    #1 chk("sat_clr", ill_cnt2, 0);
    in_valid2 = 1; ill_clr2 = 0;
    @(posedge Clk);
    #1 chk("sat_one", ill_cnt2, 1);
    ill_clr2 = 1;
    @(posedge Clk);
    #1 chk("clr_wins", ill_cnt2, 0);
    in_valid2 = 0; ill_clr2 = 0;

    // Reset with two records held.
    drive(1, 16'h1283, 0, 0);
    drive(1, 16'hF000, 0, 0);
    drive(0, 16'h0000, 0, 0);
    @(negedge Clk);
    chk("pre_rst_valid", out_valid, 1);
`ifdef SLC3_GPU_OPS_EN
    chk("pre_rst_ill", ill_cnt, 1);
`else
    chk("pre_rst_ill", ill_cnt, 2);
`endif
    #2 Reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ill", ill_cnt, 0);
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    @(negedge Clk);
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_valid", out_valid, 0);
    out_ready = 1;
    repeat (2) @(negedge Clk);
    chk("post_rst_empty", out_valid, 0);

    // Random traffic, checked every cycle by the model process.
    for (int i = 0; i < 3000; i++) begin
      @(posedge Clk);
      #1;
      in_valid  = ($urandom_range(0, 9) < 7);
      in_instr  = pick();
      out_ready = ($urandom_range(0, 9) < 6);
      ill_clr   = ($urandom_range(0, 39) == 0);
    end
    drive(0, 16'h0000, 1, 0);
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/slc3_instr_decoder.md
SLC3_INSTR_DECODER -- requirements
Module: slc3_instr_decoder

Interface
REQ-001 Parameters SHALL be as follows.
- ILL_CNT_W, default 16: width of the illegal-instruction counter.
REQ-002 The block SHALL use one clock. Reset SHALL be asynchronous and active-low.
REQ-003 Ports SHALL be as follows (name, direction, width, meaning):
- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  decoder can accept
- in_instr  in  16  raw SLC3 instruction word
- out_valid  out  1  decoded record available
- out_ready  in  1  consumer takes record
- op_class  out  4  0 NOP, 1 ADD, 2 AND, 3 NOT, 4 BR, 5 JMP, 6 JSR, 7 LDR, 8 STR, 9 PSE, 10 WPIX, 11 GRSC, 12 INVR, 13 PUB, 14 BRTN, 15 ILL
- dr  out  3  destination register or STR source, [11:9]
- sr1  out  3  [8:6] (BaseR for JMP/LDR/STR)
- sr2  out  3  [2:0]
- imm_sel  out  1  operand 2 is immediate
- imm  out  16  sign-extended immediate/offset
- nzp  out  3  branch condition [11:9]
- pix  out  8  WPIX pixel [7:0]
- ill_cnt  out  ILL_CNT_W  count of illegal words decoded
- ill_clr  in  1  synchronous counter clear

Function
REQ-004 A word SHALL be accepted on a rising edge with in_valid=1 and in_ready=1.
REQ-005 Decode SHALL be registered. An accepted word SHALL be visible at the output no earlier than the next cycle, giving 1-cycle latency when the output is empty.
REQ-006 Decoded records SHALL be held in a 2-entry FIFO.
- in_ready=1 iff fewer than 2 entries are held, or out_ready=1 while full.
- Order SHALL be preserved.
REQ-007 An output record SHALL be removed on a cycle with out_valid=1 and out_ready=1. Output fields SHALL remain stable while out_valid=1 and out_ready=0.
REQ-008 A simultaneous push and pop SHALL keep the occupancy unchanged. Push and pop on an empty FIFO SHALL NOT bypass; the record appears the next cycle.
REQ-009 ADD and AND (0001, 0101) decode rules:
- bit5=0 gives imm_sel=0.
- bit5=1 gives imm_sel=1 and imm=sext([4:0]).
REQ-010 NOT (1001) SHALL ignore [5:0].
REQ-011 BR (0000) decode rules:
- nzp=000 gives NOP.
- Otherwise BR with imm=sext([8:0]).
REQ-012 JMP (1100) SHALL decode sr1=[8:6]. RET is JMP with sr1=7.
REQ-013 JSR (0100) decode rules:
- bit11=1 gives JSR with imm=sext([10:0]).
- bit11=0 gives ILL.
REQ-014 LDR and STR (0110, 0111) SHALL decode imm=sext([5:0]).
REQ-015 PSE (1101) SHALL decode imm={4'b0,[11:0]}.
REQ-016 The following encodings SHALL decode as WPIX, GRSC, INVR, PUB and BRTN when GPU_OPS_EN is defined:
- WPIX: [15:8]=0x2F, pix=[7:0].
- GRSC: 0xE000.
- INVR: 0xE800.
- PUB: 0xE020.
- BRTN: [15:3]=0x0600, imm={13'b0,[2:0]}.
REQ-017 All other words SHALL decode as ILL, with every field except op_class driven to 0.
REQ-018 ill_cnt SHALL increment by 1 when an ILL record is accepted into the FIFO. It SHALL saturate at all-ones and never wrap.
REQ-019 ill_clr SHALL zero ill_cnt. When ill_clr and an ILL acceptance occur in the same cycle, ill_cnt SHALL become 0.
REQ-020 Fields not meaningful for an op class SHALL be driven to 0.

Reset
REQ-021 On Reset_n=0 the FIFO SHALL be emptied and out_valid, ill_cnt and all output fields SHALL be 0. in_ready=1 in the first cycle after deassertion.
REQ-022 Reset asserted mid-operation SHALL discard all held records. No record SHALL appear after release.

Configuration
REQ-023 Macro SLC3_GPU_OPS_EN SHALL control the GPU extension opcodes.
- Defined: REQ-016 decode is active.
- Undefined: WPIX, GRSC, INVR, PUB and BRTN encodings decode as ILL and increment ill_cnt. op_class codes 10-14 are never produced.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- 0x1283 into an empty decoder with out_ready=1 -> next cycle ADD, dr=1, sr1=2, sr2=3, imm_sel=0.
- 0x127F, then 0x0FFF, then 0x0000 -> ADD imm=0xFFFF imm_sel=1; BR nzp=7 imm=0xFFFF; NOP.
- 0x2FE0 -> with GPU_OPS_EN: WPIX pix=0xE0, ill_cnt=0. Without it: ILL, ill_cnt=1.
- out_ready=0, offer 0x5020, 0x9BFF, 0xC1C0 -> first two accepted, in_ready=0, third held. Then out_ready=1 -> AND, NOT, JMP in order, no loss or duplication.
- ILL_CNT_W=2, five 0xF000 words -> ill_cnt 1,2,3,3,3. Then ill_clr -> 0.
- Two records held, pulse Reset_n low -> out_valid=0, ill_cnt=0 immediately, in_ready=1 after release.
